// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter.
// Build with RAM_ARB_RR_EN defined for round-robin arbitration.
package ram_arb_pkg;

    localparam int NUM_MASTERS   = 2;
    localparam int ARB_MEM_DEPTH = 256;
    localparam int ARB_AW        = $clog2(ARB_MEM_DEPTH);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic              we;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
    } mem_req_t;

endpackage

// File: rtl/ram_arbiter_arb2.sv
// Two-way request to one-hot grant.
// RAM_ARB_RR_EN adds a round-robin preference pointer; else M1 wins.
module arb2
    import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
    input  logic                   clk_i,
    input  logic                   rst_ni,
`endif
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] gnt_o
);

`ifdef RAM_ARB_RR_EN
    // r_ptr = 0 prefers M0, 1 prefers M1
    logic r_ptr;

    always_comb begin
        gnt_o = '0;
        if (req_i[0] && (!req_i[1] || !r_ptr))
            gnt_o[0] = 1'b1;
        else if (req_i[1])
            gnt_o[1] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_ptr <= 1'b0;
        else if (gnt_o[0])
            r_ptr <= 1'b1;
        else if (gnt_o[1])
            r_ptr <= 1'b0;
    end
`else
    always_comb begin
        gnt_o    = '0;
        gnt_o[1] = req_i[1];
        gnt_o[0] = req_i[0] & ~req_i[1];
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch (M0) and load/store (M1).
// Optional RAM_ARB_RR_EN selects round-robin instead of M1 priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int MEM_DEPTH = ARB_MEM_DEPTH,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          m0_req_i,
    output logic          m0_gnt_o,
    input  logic [AW+1:2] m0_addr_i,
    input  logic          m0_we_i,
    input  logic [31:0]   m0_wdata_i,
    input  logic [3:0]    m0_wstrb_i,
    output logic          m0_rvalid_o,
    output logic [31:0]   m0_rdata_o,

    input  logic          m1_req_i,
    output logic          m1_gnt_o,
    input  logic [AW+1:2] m1_addr_i,
    input  logic          m1_we_i,
    input  logic [31:0]   m1_wdata_i,
    input  logic [3:0]    m1_wstrb_i,
    output logic          m1_rvalid_o,
    output logic [31:0]   m1_rdata_o,

    output logic          ram_en_o,
    output logic          ram_wen_o,
    output logic [AW+1:2] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    output logic [3:0]    ram_wstrb_o,
    input  logic [31:0]   ram_rdata_i
);

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_gnt;
    mem_req_t               w_m0;
    mem_req_t               w_m1;
    mem_req_t               w_sel;
    owner_e                 r_owner;

    // Requests are masked in reset so no grant escapes while rst_ni is low
    assign w_req = {m1_req_i, m0_req_i} & {NUM_MASTERS{rst_ni}};

    arb2 u_arb2 (
`ifdef RAM_ARB_RR_EN
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
`endif
        .req_i  (w_req),
        .gnt_o  (w_gnt)
    );

    assign m0_gnt_o = w_gnt[0];
    assign m1_gnt_o = w_gnt[1];

    assign w_m0 = '{addr:  ARB_AW'(m0_addr_i), we: m0_we_i,
                    wdata: m0_wdata_i, wstrb: m0_wstrb_i};
    assign w_m1 = '{addr:  ARB_AW'(m1_addr_i), we: m1_we_i,
                    wdata: m1_wdata_i, wstrb: m1_wstrb_i};

    always_comb begin
        w_sel = '0;
        unique case (1'b1)
            w_gnt[1]: w_sel = w_m1;
            w_gnt[0]: w_sel = w_m0;
            default:  w_sel = '0;
        endcase
    end

    assign ram_en_o    = |w_gnt;
    assign ram_wen_o   = w_sel.we;
    assign ram_addr_o  = AW'(w_sel.addr);
    assign ram_wdata_o = w_sel.wdata;
    assign ram_wstrb_o = w_sel.wstrb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner <= OWN_NONE;
        end else begin
            unique case (1'b1)
                w_gnt[1]: r_owner <= OWN_M1;
                w_gnt[0]: r_owner <= OWN_M0;
                default:  r_owner <= OWN_NONE;
            endcase
        end
    end

    assign m0_rvalid_o = (r_owner == OWN_M0);
    assign m1_rvalid_o = (r_owner == OWN_M1);
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle RAM.
// Contention expectations follow RAM_ARB_RR_EN when defined.
module tb_ram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
    logic [9:2]  m0_addr_i;
    logic [31:0] m0_wdata_i, m0_rdata_o;
    logic [3:0]  m0_wstrb_i;
    logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
    logic [9:2]  m1_addr_i;
    logic [31:0] m1_wdata_i, m1_rdata_o;
    logic [3:0]  m1_wstrb_i;
    logic        ram_en_o, ram_wen_o;
    logic [9:2]  ram_addr_o;
    logic [31:0] ram_wdata_o, ram_rdata_i;
    logic [3:0]  ram_wstrb_o;

    logic        tb_load;
    logic [31:0] mem [0:255];
    int          errors = 0;
    int          checks = 0;

    always #5 clk_i = ~clk_i;

    ram_arbiter #(.MEM_DEPTH(256)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i),
        .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i),
        .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_wstrb_o(ram_wstrb_o),
        .ram_rdata_i(ram_rdata_i)
    );

    // Single-port RAM: read returns the pre-write word one cycle later
    always @(posedge clk_i) begin
        if (tb_load) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'hAABBCCDD;
        end else if (ram_en_o) begin
            ram_rdata_i <= mem[ram_addr_o];
            if (ram_wen_o)
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb_o[b])
                        mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
    endtask

    task automatic test_reset();
        m0_req_i = 1; m0_addr_i = 8'h10;
        #1;
        checks++;
        if ({m0_gnt_o, m1_gnt_o, ram_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 000", {m0_gnt_o, m1_gnt_o, ram_en_o});
        end
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid_o, m1_rvalid_o});
        end
        idle();
        rst_ni = 1;
        step();
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o, ram_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_state: got %b want 000", {m0_rvalid_o, m1_rvalid_o, ram_en_o});
        end
    endtask

    task automatic test_m0_read();
        m0_req_i = 1; m0_addr_i = 8'h10;
        #1;
        checks++;
        if ({m0_gnt_o, m1_gnt_o, ram_en_o, ram_wen_o} !== 4'b1010) begin
            errors++;
            $display("FAIL m0_read_gnt: got %b want 1010", {m0_gnt_o, m1_gnt_o, ram_en_o, ram_wen_o});
        end
        checks++;
        if (ram_addr_o !== 8'h10) begin
            errors++;
            $display("FAIL m0_read_addr: got %h want 10", ram_addr_o);
        end
        step();
        idle();
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin
            errors++;
            $display("FAIL m0_read_rvalid: got %b want 10", {m0_rvalid_o, m1_rvalid_o});
        end
        checks++;
        if (m0_rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL m0_read_data: got %h want deadbeef", m0_rdata_o);
        end
        #1;
        checks++;
        if ({ram_en_o, ram_addr_o} !== 9'd0) begin
            errors++;
            $display("FAIL no_grant_bus: got %b/%h want 0/00", ram_en_o, ram_addr_o);
        end
    endtask

    task automatic test_m1_write();
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 8'h20;
        m1_wdata_i = 32'h11223344; m1_wstrb_i = 4'b0101;
        #1;
        checks++;
        if ({m1_gnt_o, m0_gnt_o, ram_wen_o, ram_wstrb_o} !== 7'b1010101) begin
            errors++;
            $display("FAIL m1_write_ctl: got %b want 1010101",
                     {m1_gnt_o, m0_gnt_o, ram_wen_o, ram_wstrb_o});
        end
        checks++;
        if ({ram_addr_o, ram_wdata_o} !== {8'h20, 32'h11223344}) begin
            errors++;
            $display("FAIL m1_write_bus: got %h/%h want 20/11223344", ram_addr_o, ram_wdata_o);
        end
        step();
        idle();
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin
            errors++;
            $display("FAIL m1_write_ack: got %b want 01", {m0_rvalid_o, m1_rvalid_o});
        end
        m0_req_i = 1; m0_addr_i = 8'h20;
        step();
        idle();
        checks++;
        if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'hAA22CC44}) begin
            errors++;
            $display("FAIL m1_write_readback: got %b/%h want 1/aa22cc44", m0_rvalid_o, m0_rdata_o);
        end
    endtask

    task automatic test_contention();
        logic exp1;
        // Async pulse restores the round-robin pointer to M0
        #1 rst_ni = 0;
        #1 rst_ni = 1;
        m0_req_i = 1; m0_addr_i = 8'h10;
        m1_req_i = 1; m1_addr_i = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef RAM_ARB_RR_EN
            exp1 = (i % 2 == 1);
`else
            exp1 = 1'b1;
`endif
            checks++;
            if ({m1_gnt_o, m0_gnt_o} !== {exp1, ~exp1}) begin
                errors++;
                $display("FAIL contend_gnt[%0d]: got %b want %b", i,
                         {m1_gnt_o, m0_gnt_o}, {exp1, ~exp1});
            end
            checks++;
            if (ram_addr_o !== (exp1 ? 8'h20 : 8'h10)) begin
                errors++;
                $display("FAIL contend_addr[%0d]: got %h want %h", i,
                         ram_addr_o, exp1 ? 8'h20 : 8'h10);
            end
            step();
            checks++;
            if ({m1_rvalid_o, m0_rvalid_o} !== {exp1, ~exp1}) begin
                errors++;
                $display("FAIL contend_rvalid[%0d]: got %b want %b", i,
                         {m1_rvalid_o, m0_rvalid_o}, {exp1, ~exp1});
            end
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        m0_req_i = 1; m0_addr_i = 8'h10;
        #1;
        checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_gnt0: got %b want 10", {m0_gnt_o, m1_gnt_o});
        end
        step();
        idle();
        m1_req_i = 1; m1_addr_i = 8'h20;
        #1;
        checks++;
        if ({m0_rvalid_o, m0_rdata_o, m1_gnt_o} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
            errors++;
            $display("FAIL b2b_cycle1: got %b/%h/%b want 1/deadbeef/1",
                     m0_rvalid_o, m0_rdata_o, m1_gnt_o);
        end
        step();
        idle();
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o, m1_rdata_o} !== {2'b01, 32'hAA22CC44}) begin
            errors++;
            $display("FAIL b2b_cycle2: got %b/%h want 01/aa22cc44",
                     {m0_rvalid_o, m1_rvalid_o}, m1_rdata_o);
        end
        step();
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o, ram_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_drain: got %b want 000", {m0_rvalid_o, m1_rvalid_o, ram_en_o});
        end
    endtask

    task automatic test_reset_mid_op();
        m1_req_i = 1; m1_addr_i = 8'h10;
        step();
        idle();
        checks++;
        if (m1_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL midop_pending: got %b want 1", m1_rvalid_o);
        end
        #2 rst_ni = 0;
        #1;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL midop_async: got %b want 00", {m0_rvalid_o, m1_rvalid_o});
        end
        step();
        rst_ni = 1;
        step();
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL midop_after: got %b want 00", {m0_rvalid_o, m1_rvalid_o});
        end
        // Reset lands between grant and its capturing edge
        m0_req_i = 1; m0_addr_i = 8'h10;
        #1;
        checks++;
        if (m0_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL gnt_pre_reset: got %b want 1", m0_gnt_o);
        end
        #1 rst_ni = 0;
        #1;
        checks++;
        if ({m0_gnt_o, ram_en_o} !== 2'b00) begin
            errors++;
            $display("FAIL gnt_in_reset: got %b want 00", {m0_gnt_o, ram_en_o});
        end
        step();
        idle();
        rst_ni = 1;
        #1;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL stale_resp0: got %b want 00", {m0_rvalid_o, m1_rvalid_o});
        end
        step();
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL stale_resp1: got %b want 00", {m0_rvalid_o, m1_rvalid_o});
        end
    endtask

    initial begin
        rst_ni  = 0;
        tb_load = 1;
        idle();
        step();
        step();
        tb_load = 0;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
